// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port unified memory between the fetch stage and the MEM
// stage. Requests are served one at a time through an IDLE -> BUSY -> RESP
// sequence. BUSY waits for mem_ready, or gives up after TIMEOUT cycles and
// completes with bus_err. stall holds the pipeline while any request is
// still outstanding.
//
// Build option:
//   MEM_ARB_FAIR_EN  When both requesters contend, grant the one that did not
//                    win last time. When undefined, data always wins.
//
// Ports:
//   clock, reset             clock; synchronous active-high reset
//   if_req/if_addr           fetch read request (held until if_ack)
//   if_rdata/if_ack          fetch read data and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata data request (held until d_ack)
//   d_rdata/d_ack            data read result and one-cycle completion pulse
//   bus_err                  pulses with the ack of a timed-out access
//   stall                    pipeline hold request
//   mem_req/mem_we/mem_addr/mem_wdata  memory access outputs
//   mem_rdata/mem_ready      memory read data and completion
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              bus_err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state_q,     state_d;
    logic              grant_q,     grant_d;
    logic              last_q,      last_d;
    logic [7:0]        cnt_q,       cnt_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic              bus_err_q,   bus_err_d;

    logic prefer_data;
    logic pick_data;
    logic done_ok;
    logic done_tmo;

`ifdef MEM_ARB_FAIR_EN
    // Alternate: data is preferred only if fetch won the previous grant.
    assign prefer_data = (last_q == GRANT_FETCH);
`else
    // last_grant is still tracked, but data wins contention regardless.
    assign prefer_data = (last_q == GRANT_DATA) | 1'b1;
`endif

    assign pick_data = d_req & (~if_req | prefer_data);
    assign done_ok   = (state_q == BUSY) & mem_ready;
    assign done_tmo  = (state_q == BUSY) & ~mem_ready &
                       (TIMEOUT != 0) & (cnt_q == TIMEOUT_CNT);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        bus_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (if_req | d_req) begin
                    grant_d     = pick_data;
                    last_d      = pick_data;
                    mem_addr_d  = pick_data ? d_addr : if_addr;
                    mem_we_d    = pick_data & d_we;
                    mem_wdata_d = pick_data ? d_wdata : '0;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (done_ok) begin
                    if (grant_q == GRANT_FETCH) begin
                        if_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (done_tmo) begin
                    // A timed-out access returns zero to whoever won it.
                    if (grant_q == GRANT_FETCH) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                    bus_err_d = 1'b1;
                end
                if (done_ok | done_tmo) begin
                    // Acks are registered so they line up with the RESP cycle.
                    if_ack_d = (grant_q == GRANT_FETCH);
                    d_ack_d  = (grant_q == GRANT_DATA);
                    state_d  = RESP;
                end
            end
            RESP: begin
                // Requesters still hold req while seeing their ack; ignore them.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= GRANT_FETCH;
            last_q      <= GRANT_FETCH;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign bus_err   = bus_err_q;

    // Combinational on purpose: the pipeline must freeze in the same cycle a
    // request appears, and release in the cycle its ack is seen.
    assign stall = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we, mem_ready;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_ack, d_ack, bus_err, stall, mem_req, mem_we;

    // Memory stand-in: either a fixed word or a function of the address.
    logic          use_fn;
    logic [DW-1:0] rd_const;

    function automatic logic [DW-1:0] fn(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata = use_fn ? fn(mem_addr) : rd_const;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            is_d;
        logic [DW-1:0] rdata;
        bit            err;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic exp_t mk(input bit is_d, input logic [DW-1:0] rd, input bit err, input int lat);
        exp_t e;
        e.is_d = is_d; e.rdata = rd; e.err = err; e.lat = lat;
        return e;
    endfunction

    // Advance until an ack appears (bounded), then compare against the
    // oldest scoreboard entry: latency in cycles, which port, data, bus_err.
    task automatic wait_ack(input string tag);
        int   n;
        exp_t e;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(if_ack || d_ack) && n < 20);
        check({tag, "_ack_seen"}, 64'(if_ack | d_ack), 64'd1);
        if (!(if_ack || d_ack)) return;
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_latency"}, 64'(n), 64'(e.lat));
        check({tag, "_which_ack"}, {62'd0, d_ack, if_ack}, e.is_d ? 64'd2 : 64'd1);
        check({tag, "_rdata"}, 64'(e.is_d ? d_rdata : if_rdata), 64'(e.rdata));
        check({tag, "_bus_err"}, 64'(bus_err), 64'(e.err));
    endtask

    initial begin
        reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; use_fn = 0; rd_const = '0;

        // Reset state
        tick(); tick();
        check("rst_if_ack", 64'(if_ack), 0);
        check("rst_d_ack", 64'(d_ack), 0);
        check("rst_bus_err", 64'(bus_err), 0);
        check("rst_mem_req", 64'(mem_req), 0);
        check("rst_mem_we", 64'(mem_we), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        check("rst_mem_wdata", 64'(mem_wdata), 0);
        check("rst_if_rdata", 64'(if_rdata), 0);
        check("rst_d_rdata", 64'(d_rdata), 0);
        check("rst_stall", 64'(stall), 0);
        reset = 1'b0;
        tick();

        // Single fetch, mem_ready at first BUSY cycle
        if_req = 1; if_addr = 32'h40; rd_const = 32'h2008_0005; mem_ready = 1;
        #1 check("f1_stall_on", 64'(stall), 1);
        sb.push_back(mk(0, 32'h2008_0005, 0, 1));
        tick();
        check("f1_mem_req", 64'(mem_req), 1);
        check("f1_mem_addr", 64'(mem_addr), 32'h40);
        check("f1_mem_we", 64'(mem_we), 0);
        wait_ack("f1");
        check("f1_stall_off", 64'(stall), 0);
        check("f1_resp_mem_req", 64'(mem_req), 0);
        if_req = 0; mem_ready = 0;
        tick();
        check("f1_ack_pulse", 64'(if_ack), 0);

        // Data read, to load d_rdata before the write
        d_req = 1; d_we = 0; d_addr = 32'h200; use_fn = 1; mem_ready = 1;
        sb.push_back(mk(1, fn(32'h200), 0, 2));
        wait_ack("drd");
        d_req = 0; mem_ready = 0;
        tick();

        // Data write, mem_ready two cycles late
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        sb.push_back(mk(1, fn(32'h200), 0, 1));
        tick();
        check("wr_b1_mem_req", 64'(mem_req), 1);
        check("wr_b1_mem_we", 64'(mem_we), 1);
        check("wr_b1_mem_addr", 64'(mem_addr), 32'h100);
        check("wr_b1_mem_wdata", 64'(mem_wdata), 32'hDEAD_BEEF);
        tick();
        check("wr_b2_mem_req", 64'(mem_req), 1);
        check("wr_b2_d_ack", 64'(d_ack), 0);
        tick();
        check("wr_b3_mem_req", 64'(mem_req), 1);
        check("wr_b3_mem_wdata", 64'(mem_wdata), 32'hDEAD_BEEF);
        mem_ready = 1;
        wait_ack("wr");
        d_req = 0; d_we = 0; mem_ready = 0;
        tick();
        check("wr_d_ack_once", 64'(d_ack), 0);

        // Contention: data first, then fetch three cycles later
        if_req = 1; if_addr = 32'h600; d_req = 1; d_addr = 32'h700; mem_ready = 1;
        sb.push_back(mk(1, fn(32'h700), 0, 2));
        sb.push_back(mk(0, fn(32'h600), 0, 3));
        tick();
        check("ct_mem_addr", 64'(mem_addr), 32'h700);
        check("ct_stall", 64'(stall), 1);
        sb[0].lat = 1;
        wait_ack("ct_d");
        check("ct_stall_fetch_pending", 64'(stall), 1);
        d_req = 0;
        wait_ack("ct_f");
        if_req = 0; mem_ready = 0;
        tick();

        // Timeout with TIMEOUT=4: ack + bus_err at t+6
        if_req = 1; if_addr = 32'h80; mem_ready = 0;
        sb.push_back(mk(0, 32'h0, 1, 6));
        wait_ack("tmo");
        check("tmo_mem_req", 64'(mem_req), 0);
        if_req = 0;
        tick();
        mem_ready = 1;
        tick();
        tick();
        check("tmo_late_if_ack", 64'(if_ack), 0);
        check("tmo_late_bus_err", 64'(bus_err), 0);
        check("tmo_late_mem_req", 64'(mem_req), 0);
        check("tmo_late_if_rdata", 64'(if_rdata), 0);
        mem_ready = 0;
        tick();

        // Reset at the second BUSY cycle abandons the access
        d_req = 1; d_we = 0; d_addr = 32'h300; mem_ready = 0;
        tick();
        check("rb_b1_mem_req", 64'(mem_req), 1);
        tick();
        check("rb_b2_mem_req", 64'(mem_req), 1);
        reset = 1;
        tick();
        check("rb_mem_req", 64'(mem_req), 0);
        check("rb_d_ack", 64'(d_ack), 0);
        reset = 0; d_req = 0; mem_ready = 1;
        tick();
        check("rb_post_d_ack0", 64'(d_ack), 0);
        mem_ready = 0;
        tick();
        check("rb_post_d_ack1", 64'(d_ack), 0);
        check("rb_post_if_ack", 64'(if_ack), 0);
        check("rb_post_mem_req", 64'(mem_req), 0);

        // Hold if_req through three accesses: acks at 3-cycle spacing
        if_req = 1; if_addr = 32'h500; mem_ready = 1; use_fn = 1;
        sb.push_back(mk(0, fn(32'h500), 0, 2));
        sb.push_back(mk(0, fn(32'h500), 0, 3));
        sb.push_back(mk(0, fn(32'h500), 0, 3));
        wait_ack("hold1");
        wait_ack("hold2");
        wait_ack("hold3");
        if_req = 0; mem_ready = 0;
        tick();
        check("hold_idle_mem_req", 64'(mem_req), 0);
        tick();
        check("hold_no_extra_req", 64'(mem_req), 0);
        check("hold_no_extra_ack", 64'(if_ack), 0);
        check("sb_drained", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
